// File: rtl/lcd_result_formatter.sv
// Purpose : latch a reaction-timer result, convert it to BCD and stream a
//           16-character ASCII line to the LCD character driver, then ack.
// Latency : first char TIME_W cycles after accept; LCDAck at TIME_W+16 with CharReady high.
// Backpressure: CharValid/CharReady; CharOut/CharAddr hold while CharReady=0.
// Ports   : Clk, Rst (async, active-high) | LCDUpdate/LCDAck four-phase request,
//           ReactionTime/Cheat/Slow result inputs | CharOut/CharAddr/CharValid/
//           CharReady character stream | Busy (not IDLE).
module lcd_result_formatter #(
   parameter int TIME_W   = 10,
   parameter int LINE_LEN = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              LCDUpdate,
   input  logic [TIME_W-1:0] ReactionTime,
   input  logic              Cheat,
   input  logic              Slow,
   output logic              LCDAck,
   output logic [7:0]        CharOut,
   output logic [3:0]        CharAddr,
   output logic              CharValid,
   input  logic              CharReady,
   output logic              Busy
);

   typedef enum logic [1:0] {IDLE, CONVERT, SEND, ACK} state_t;

   localparam logic [8*16-1:0] CHEAT_STR = "CHEATER!        ";
   localparam logic [8*16-1:0] SLOW_STR  = "TOO SLOW        ";
   localparam logic [8*16-1:0] TIME_STR  = "TIME:  000 MS   ";

   state_t            state_q, state_d;
   logic [TIME_W-1:0] time_q, time_d;    // doubles as the conversion shift register
   logic              cheat_q, cheat_d;
   logic              slow_q, slow_d;
   logic [15:0]       bcd_q, bcd_d;
   logic [15:0]       bcd_adj;
   logic [3:0]        cnt_q, cnt_d;
   logic [3:0]        addr_q, addr_d;
   logic [7:0]        char_c;
   logic              blank3, blank2, blank1;
   int                col_sh;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         time_q  <= '0;
         cheat_q <= 1'b0;
         slow_q  <= 1'b0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         time_q  <= time_d;
         cheat_q <= cheat_d;
         slow_q  <= slow_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
      end
   end

   // Add 3 to every BCD nibble >= 5 so the following shift carries correctly.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      cheat_d = cheat_q;
      slow_d  = slow_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (LCDUpdate) begin
               time_d  = ReactionTime;
               cheat_d = Cheat;
               slow_d  = Slow;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            // Value has at most 13 bits (< 8192), so bcd_adj[15] never carries out.
            bcd_d  = (bcd_adj << 1) | 16'(time_q[TIME_W-1]);
            time_d = time_q << 1;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'(TIME_W-1)) begin
               addr_d  = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (CharReady) begin
               addr_d = addr_q + 4'd1;
               if (addr_q == 4'(LINE_LEN-1))
                  state_d = ACK;
            end
         end
         ACK: begin
            if (!LCDUpdate)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Leading-zero blanking: a digit blanks only if it and every digit left of it is 0;
   // the units digit always prints.
   assign blank3 = (bcd_q[15:12] == 4'd0);
   assign blank2 = blank3 && (bcd_q[11:8] == 4'd0);
   assign blank1 = blank2 && (bcd_q[7:4] == 4'd0);

   always_comb begin
      char_c = 8'h00;
      col_sh = 8 * (LINE_LEN - 1 - int'(addr_q));
      if (cheat_q)
         char_c = CHEAT_STR[col_sh +: 8];
      else if (slow_q)
         char_c = SLOW_STR[col_sh +: 8];
      else begin
         case (addr_q)
            4'd6:    char_c = blank3 ? 8'h20 : {4'h3, bcd_q[15:12]};
            4'd7:    char_c = blank2 ? 8'h20 : {4'h3, bcd_q[11:8]};
            4'd8:    char_c = blank1 ? 8'h20 : {4'h3, bcd_q[7:4]};
            4'd9:    char_c = {4'h3, bcd_q[3:0]};
            default: char_c = TIME_STR[col_sh +: 8];
         endcase
      end
   end

   assign CharValid = (state_q == SEND);
   assign CharOut   = (state_q == SEND) ? char_c : 8'h00;
   assign CharAddr  = addr_q;
   assign LCDAck    = (state_q == ACK);
   assign Busy      = (state_q != IDLE);

endmodule
